// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - coin codes, coin values, FSM states and 7-segment encoding for the vending controller
package vend_pkg;

  localparam logic [11:0] COIN_PENNY   = 12'hBC0;
  localparam logic [11:0] COIN_NICKEL  = 12'hD00;
  localparam logic [11:0] COIN_DIME    = 12'hB00;
  localparam logic [11:0] COIN_QUARTER = 12'hEF0;

  localparam logic [7:0] VAL_PENNY   = 8'd1;
  localparam logic [7:0] VAL_NICKEL  = 8'd5;
  localparam logic [7:0] VAL_DIME    = 8'd10;
  localparam logic [7:0] VAL_QUARTER = 8'd25;

  typedef enum logic {
    IDLE = 1'b0,
    VEND = 1'b1
  } state_e;

  // Segment pattern {g,f,e,d,c,b,a}, active-high; non-decimal codes blank the digit
  function automatic logic [6:0] seg7_encode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Value in cents of a received frame; zero means the frame is not a known coin
  function automatic logic [7:0] coin_value(input logic [31:0] frame);
    logic [7:0] val;
    val = 8'd0;
    if (frame == 32'(COIN_PENNY))   val = VAL_PENNY;
    if (frame == 32'(COIN_NICKEL))  val = VAL_NICKEL;
    if (frame == 32'(COIN_DIME))    val = VAL_DIME;
    if (frame == 32'(COIN_QUARTER)) val = VAL_QUARTER;
    return val;
  endfunction

endpackage

// File: rtl/vend_seg7.sv
// rtl/vend_seg7.sv - one BCD digit to 7-segment pattern
module vend_seg7 (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  import vend_pkg::*;

  assign seg = seg7_encode(bcd);

endmodule

// File: rtl/vend_ctrl_param.sv
// rtl/vend_ctrl_param.sv - parametrised vending controller: coin frames, credit, vend/refund, credit display
module vend_ctrl_param #(
  parameter int                        FRAME_W      = 12,
  parameter int                        NUM_PRODUCTS = 4,
  parameter logic [8*NUM_PRODUCTS-1:0] PRICES       = {8'd95, 8'd75, 8'd60, 8'd50},
  parameter int                        CREDIT_MAX   = 99,
  parameter int                        NUM_DIGITS   = 2,
  parameter int                        VEND_CYCLES  = 4,
  localparam int                       PW           = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1,
  localparam int                       CW           = $clog2(CREDIT_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    serialIn,
  input  logic                    enable,
  input  logic                    buy,
  input  logic [PW-1:0]           product,
  input  logic                    refund,
  output logic [7*NUM_DIGITS-1:0] digits,
  output logic                    dispense,
  output logic [PW-1:0]           dispense_id,
  output logic                    change_valid,
  output logic [CW-1:0]           change_amt,
  output logic                    coin_reject,
  output logic                    insufficient,
  output logic                    busy
);
  import vend_pkg::*;

  localparam int LW = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;

  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               enable_prev_q, buy_prev_q, refund_prev_q;
  logic [CW-1:0]      credit_q, credit_d;
  state_e             state_q, state_d;
  logic [LW-1:0]      cnt_q, cnt_d;
  logic               buy_pend_q, buy_pend_d;
  logic               refund_pend_q, refund_pend_d;
  logic               dispense_q, dispense_d;
  logic [PW-1:0]      dispense_id_q, dispense_id_d;
  logic               change_valid_q, change_valid_d;
  logic [CW-1:0]      change_amt_q, change_amt_d;
  logic               coin_reject_q, coin_reject_d;
  logic               insufficient_q, insufficient_d;

  logic               frame_end, buy_req, refund_req, prod_ok;
  logic [7:0]         coin_val, price;

  // Next-state: frame shifting/acceptance, request arbitration, vend lockout
  always_comb begin
    shift_d        = shift_q;
    credit_d       = credit_q;
    state_d        = state_q;
    cnt_d          = cnt_q;
    buy_pend_d     = 1'b0;
    refund_pend_d  = 1'b0;
    dispense_d     = 1'b0;
    dispense_id_d  = '0;
    change_valid_d = 1'b0;
    change_amt_d   = '0;
    coin_reject_d  = 1'b0;
    insufficient_d = 1'b0;

    frame_end  = enable_prev_q & ~enable;
    buy_req    = (buy & ~buy_prev_q) | buy_pend_q;
    refund_req = (refund & ~refund_prev_q) | refund_pend_q;
    coin_val   = coin_value(32'(shift_q));
    prod_ok    = int'(product) < NUM_PRODUCTS;
    price      = 8'd0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (int'(product) == i) price = PRICES[8*i +: 8];
    end

    if (enable) shift_d = {serialIn, shift_q[FRAME_W-1:1]};

    if (frame_end) begin
      shift_d = '0;
      if (state_q == IDLE && coin_val != 8'd0 &&
          int'(credit_q) + int'(coin_val) <= CREDIT_MAX)
        credit_d = CW'(int'(credit_q) + int'(coin_val));
      else
        coin_reject_d = 1'b1;
    end

    if (state_q == VEND) begin
      // Requests during lockout are dropped, not queued
      if (cnt_q == '0) state_d = IDLE;
      else             cnt_d   = cnt_q - 1'b1;
    end else if (frame_end) begin
      // Coin lands first; requests are replayed next edge against the new credit
      refund_pend_d = refund_req;
      buy_pend_d    = buy_req & ~refund_req;
    end else if (refund_req) begin
      change_valid_d = 1'b1;
      change_amt_d   = credit_q;
      credit_d       = '0;
    end else if (buy_req) begin
      if (!prod_ok || int'(credit_q) < int'(price)) begin
        insufficient_d = 1'b1;
      end else begin
        dispense_d     = 1'b1;
        dispense_id_d  = product;
        change_valid_d = 1'b1;
        change_amt_d   = CW'(int'(credit_q) - int'(price));
        credit_d       = '0;
        state_d        = VEND;
        cnt_d          = LW'(VEND_CYCLES - 1);
      end
    end
  end

  // State and registered output pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q        <= '0;
      enable_prev_q  <= 1'b0;
      buy_prev_q     <= 1'b0;
      refund_prev_q  <= 1'b0;
      credit_q       <= '0;
      state_q        <= IDLE;
      cnt_q          <= '0;
      buy_pend_q     <= 1'b0;
      refund_pend_q  <= 1'b0;
      dispense_q     <= 1'b0;
      dispense_id_q  <= '0;
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
    end else begin
      shift_q        <= shift_d;
      enable_prev_q  <= enable;
      buy_prev_q     <= buy;
      refund_prev_q  <= refund;
      credit_q       <= credit_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      buy_pend_q     <= buy_pend_d;
      refund_pend_q  <= refund_pend_d;
      dispense_q     <= dispense_d;
      dispense_id_q  <= dispense_id_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
    end
  end

  assign dispense     = dispense_q;
  assign dispense_id  = dispense_id_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign coin_reject  = coin_reject_q;
  assign insufficient = insufficient_q;
  assign busy         = (state_q == VEND);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [3:0] bcd;
    assign bcd = 4'((int'(credit_q) / (10 ** g)) % 10);
    vend_seg7 u_seg (.bcd(bcd), .seg(digits[7*g +: 7]));
  end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb/tb_vend_ctrl_param.sv - self-checking bench for vend_ctrl_param
module tb_vend_ctrl_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        serial_in = 1'b0, enable = 1'b0, buy = 1'b0, refund = 1'b0;
  logic [1:0]  product = 2'd0;
  logic [13:0] digits;
  logic        dispense, change_valid, coin_reject, insufficient, busy;
  logic [1:0]  dispense_id;
  logic [6:0]  change_amt;

  always #5 clk = ~clk;

  vend_ctrl_param dut (
    .clk(clk), .reset(reset), .serialIn(serial_in), .enable(enable), .buy(buy),
    .product(product), .refund(refund), .digits(digits), .dispense(dispense),
    .dispense_id(dispense_id), .change_valid(change_valid), .change_amt(change_amt),
    .coin_reject(coin_reject), .insufficient(insufficient), .busy(busy)
  );

  localparam int OP_COIN = 0, OP_BUY = 1, OP_REFUND = 2;
  localparam logic [11:0] PENNY = 12'hBC0, NICKEL = 12'hD00, DIME = 12'hB00, QUARTER = 12'hEF0;

  typedef struct { bit rej; bit disp; bit ins; bit chg; bit busy; int id; int amt; logic [13:0] digits; } obs_t;
  typedef struct { int op; logic [11:0] arg; bit rej; bit disp; bit ins; bit chg; int amt; int credit; } vec_t;

  int checks = 0, failures = 0;
  int edge_n = 0;
  int m_credit = 0;
  int m_vend_edge = -100;
  int prices [4] = '{50, 60, 75, 95};
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  vec_t vt[$];

  function automatic logic [13:0] exp_digits(input int c);
    return {seg_tab[(c / 10) % 10], seg_tab[c % 10]};
  endfunction

  function automatic int coin_val(input logic [11:0] f);
    case (f)
      PENNY:   return 1;
      NICKEL:  return 5;
      DIME:    return 10;
      QUARTER: return 25;
      default: return 0;
    endcase
  endfunction

  function automatic bit in_vend(input int e);
    return (e >= m_vend_edge + 1) && (e <= m_vend_edge + 4);
  endfunction

  function automatic bit busy_after(input int e);
    return (e >= m_vend_edge) && (e <= m_vend_edge + 3);
  endfunction

  function automatic vec_t mk(input int op, input logic [11:0] arg, input bit rej, input bit disp,
                              input bit ins, input bit chg, input int amt, input int credit);
    vec_t v;
    v.op = op; v.arg = arg; v.rej = rej; v.disp = disp; v.ins = ins; v.chg = chg;
    v.amt = amt; v.credit = credit;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic sample(output obs_t o);
    o.rej = coin_reject; o.disp = dispense; o.ins = insufficient; o.chg = change_valid;
    o.busy = busy; o.id = int'(dispense_id); o.amt = int'(change_amt); o.digits = digits;
  endtask

  task automatic quiet(input string tag);
    tick();
    chk({tag, " no pulses"}, {28'd0, dispense, insufficient, change_valid, coin_reject}, 32'd0);
    chk({tag, " busy"}, busy, busy_after(edge_n));
  endtask

  // Reference: a transaction's effect on credit and lockout from the pricing rules
  task automatic predict(input int op, input logic [11:0] arg, output obs_t e);
    int v;
    bit vend;
    e = '{default: 0};
    vend = in_vend(edge_n);
    if (op == OP_COIN) begin
      v = coin_val(arg);
      if (vend || v == 0 || m_credit + v > 99) e.rej = 1'b1;
      else m_credit += v;
    end else if (op == OP_BUY && !vend) begin
      if (m_credit < prices[arg[1:0]]) e.ins = 1'b1;
      else begin
        e.disp = 1'b1; e.id = int'(arg[1:0]); e.chg = 1'b1;
        e.amt = m_credit - prices[arg[1:0]];
        m_credit = 0; m_vend_edge = edge_n;
      end
    end else if (op == OP_REFUND && !vend) begin
      e.chg = 1'b1; e.amt = m_credit; m_credit = 0;
    end
    e.busy = busy_after(edge_n);
    e.digits = exp_digits(m_credit);
  endtask

  task automatic do_op(input int op, input logic [11:0] arg, output obs_t o, output obs_t e);
    if (op == OP_COIN) begin
      for (int i = 0; i < 12; i++) begin
        enable = 1'b1; serial_in = arg[i];
        quiet("shift");
      end
      enable = 1'b0; serial_in = 1'b0;
    end else if (op == OP_BUY) begin
      buy = 1'b1; product = arg[1:0];
    end else begin
      refund = 1'b1;
    end
    tick();
    sample(o);
    predict(op, arg, e);
    buy = 1'b0; refund = 1'b0;
    quiet("gap");
  endtask

  task automatic compare_obs(input string tag, input obs_t o, input obs_t e);
    chk({tag, " coin_reject"}, o.rej, e.rej);
    chk({tag, " dispense"}, o.disp, e.disp);
    chk({tag, " insufficient"}, o.ins, e.ins);
    chk({tag, " change_valid"}, o.chg, e.chg);
    if (e.disp) chk({tag, " dispense_id"}, o.id, e.id);
    if (e.chg) chk({tag, " change_amt"}, o.amt, e.amt);
    chk({tag, " busy"}, o.busy, e.busy);
    chk({tag, " digits"}, o.digits, e.digits);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; enable = 1'b0; buy = 1'b0; refund = 1'b0; serial_in = 1'b0;
    #2;
    chk({tag, " digits"}, digits, 14'h1FBF);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " pulses"}, {28'd0, dispense, insufficient, change_valid, coin_reject}, 32'd0);
    @(posedge clk);
    #1;
    edge_n++;
    reset = 1'b0;
    m_credit = 0; m_vend_edge = -100;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    obs_t o, e;
    logic [11:0] f;
    int k, op, r;

    vt.push_back(mk(OP_COIN,   PENNY,   0, 0, 0, 0, 0,  1));
    vt.push_back(mk(OP_COIN,   NICKEL,  0, 0, 0, 0, 0,  6));
    vt.push_back(mk(OP_COIN,   DIME,    0, 0, 0, 0, 0, 16));
    vt.push_back(mk(OP_COIN,   QUARTER, 0, 0, 0, 0, 0, 41));
    vt.push_back(mk(OP_BUY,    12'd0,   0, 0, 1, 0, 0, 41));
    vt.push_back(mk(OP_COIN,   QUARTER, 0, 0, 0, 0, 0, 66));
    vt.push_back(mk(OP_BUY,    12'd1,   0, 1, 0, 1, 6,  0));
    vt.push_back(mk(OP_COIN,   QUARTER, 0, 0, 0, 0, 0, 25));
    vt.push_back(mk(OP_COIN,   QUARTER, 0, 0, 0, 0, 0, 50));
    vt.push_back(mk(OP_COIN,   QUARTER, 0, 0, 0, 0, 0, 75));
    vt.push_back(mk(OP_COIN,   QUARTER, 1, 0, 0, 0, 0, 75));
    vt.push_back(mk(OP_COIN,   12'h000, 1, 0, 0, 0, 0, 75));
    vt.push_back(mk(OP_REFUND, 12'd0,   0, 0, 0, 1, 75, 0));
    vt.push_back(mk(OP_BUY,    12'd3,   0, 0, 1, 0, 0,  0));
    vt.push_back(mk(OP_REFUND, 12'd0,   0, 0, 0, 1, 0,  0));
    vt.push_back(mk(OP_COIN,   DIME,    0, 0, 0, 0, 0, 10));
    vt.push_back(mk(OP_COIN,   12'hBC1, 1, 0, 0, 0, 0, 10));
    vt.push_back(mk(OP_BUY,    12'd2,   0, 0, 1, 0, 0, 10));

    do_reset("reset");

    for (int i = 0; i < vt.size(); i++) begin
      do_op(vt[i].op, vt[i].arg, o, e);
      chk($sformatf("vec%0d coin_reject", i), o.rej, vt[i].rej);
      chk($sformatf("vec%0d dispense", i), o.disp, vt[i].disp);
      chk($sformatf("vec%0d insufficient", i), o.ins, vt[i].ins);
      chk($sformatf("vec%0d change_valid", i), o.chg, vt[i].chg);
      if (vt[i].disp) chk($sformatf("vec%0d dispense_id", i), o.id, int'(vt[i].arg[1:0]));
      if (vt[i].chg) chk($sformatf("vec%0d change_amt", i), o.amt, vt[i].amt);
      chk($sformatf("vec%0d digits", i), o.digits, exp_digits(vt[i].credit));
      if (i == 3) chk("credit41 digits", o.digits, 14'h3306);
    end

    // Frame end and buy on the same edge: buy resolves one cycle later on the new credit
    do_op(OP_REFUND, 12'd0, o, e);
    do_op(OP_COIN, QUARTER, o, e);
    do_op(OP_COIN, QUARTER, o, e);
    f = QUARTER;
    for (int i = 0; i < 12; i++) begin
      enable = 1'b1; serial_in = f[i];
      quiet("t4 shift");
    end
    enable = 1'b0; buy = 1'b1; product = 2'd0;
    tick();
    chk("t4 no dispense at frame end", dispense, 1'b0);
    chk("t4 no reject", coin_reject, 1'b0);
    chk("t4 credit 75", digits, exp_digits(75));
    buy = 1'b0;
    tick();
    chk("t4 dispense", dispense, 1'b1);
    chk("t4 dispense_id", dispense_id, 2'd0);
    chk("t4 change_valid", change_valid, 1'b1);
    chk("t4 change_amt", change_amt, 7'd25);
    chk("t4 credit 0", digits, exp_digits(0));
    m_credit = 0; m_vend_edge = edge_n;
    repeat (5) quiet("t4 drain");

    // Buy and coin while locked out
    do_op(OP_COIN, QUARTER, o, e);
    do_op(OP_COIN, QUARTER, o, e);
    f = DIME;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      enable = 1'b1; serial_in = f[i];
      buy = (i == 9) || (i == 11);
      product = (i == 11) ? 2'd2 : 2'd0;
      tick();
      if (i == 9) begin
        chk("t5 first dispense", dispense, 1'b1);
        chk("t5 exact change", change_amt, 7'd0);
        k = edge_n;
      end
      if (i == 11) begin
        chk("t5 vend-time buy dispense", dispense, 1'b0);
        chk("t5 vend-time buy insufficient", insufficient, 1'b0);
      end
    end
    enable = 1'b0; buy = 1'b0;
    tick();
    chk("t5 coin_reject", coin_reject, 1'b1);
    chk("t5 credit 0", digits, exp_digits(0));
    chk("t5 busy last", busy, 1'b1);
    tick();
    chk("t5 busy released", busy, 1'b0);
    m_credit = 0; m_vend_edge = k;
    repeat (2) quiet("t5 drain");

    // Refund and buy on the same edge: refund only
    do_op(OP_COIN, QUARTER, o, e);
    do_op(OP_COIN, QUARTER, o, e);
    buy = 1'b1; product = 2'd0; refund = 1'b1;
    tick();
    chk("rb change_valid", change_valid, 1'b1);
    chk("rb change_amt", change_amt, 7'd50);
    chk("rb no dispense", dispense, 1'b0);
    chk("rb no insufficient", insufficient, 1'b0);
    buy = 1'b0; refund = 1'b0;
    m_credit = 0;
    quiet("rb after");
    chk("rb credit", digits, exp_digits(0));

    // Refund and frame end on the same edge: coin first, refund next cycle
    f = DIME;
    for (int i = 0; i < 12; i++) begin
      enable = 1'b1; serial_in = f[i];
      quiet("rf shift");
    end
    enable = 1'b0; refund = 1'b1;
    tick();
    chk("rf no change yet", change_valid, 1'b0);
    chk("rf credit 10", digits, exp_digits(10));
    refund = 1'b0;
    tick();
    chk("rf change_valid", change_valid, 1'b1);
    chk("rf change_amt", change_amt, 7'd10);
    chk("rf credit 0", digits, exp_digits(0));
    m_credit = 0;
    quiet("rf after");

    // Reset mid-vend, then reset mid-frame followed by a clean dime
    do_op(OP_COIN, QUARTER, o, e);
    do_op(OP_COIN, QUARTER, o, e);
    do_op(OP_BUY, 12'd0, o, e);
    compare_obs("t6 vend", o, e);
    for (int i = 0; i < 2; i++) begin
      enable = 1'b1; serial_in = 1'b1;
      quiet("t6 vend shift");
    end
    do_reset("reset mid-vend");
    for (int i = 0; i < 6; i++) begin
      enable = 1'b1; serial_in = 1'($urandom_range(0, 1));
      quiet("t6 partial");
    end
    do_reset("reset mid-frame");
    do_op(OP_COIN, DIME, o, e);
    compare_obs("t6 dime", o, e);
    chk("t6 credit 10", o.digits, exp_digits(10));
    do_op(OP_REFUND, 12'd0, o, e);
    compare_obs("t6 refund", o, e);
    chk("t6 refund amt", o.amt, 10);

    // Random transactions against the reference
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        op = OP_COIN;
        case ($urandom_range(0, 4))
          0: f = PENNY;
          1: f = NICKEL;
          2: f = DIME;
          3: f = QUARTER;
          default: f = 12'($urandom);
        endcase
      end else if (r <= 8) begin
        op = OP_BUY;
        f = 12'($urandom_range(0, 3));
      end else begin
        op = OP_REFUND;
        f = 12'd0;
      end
      do_op(op, f, o, e);
      compare_obs($sformatf("rand%0d", n), o, e);
      repeat ($urandom_range(0, 2)) quiet("rand idle");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
